// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, FSM state encoding and the
// instruction-width helper shared by the sequencer core.
package cpu_pkg;

  localparam int unsigned OP_NOP    = 0;
  localparam int unsigned OP_MOV    = 1;
  localparam int unsigned OP_ALU_LO = 2;
  localparam int unsigned OP_ALU_HI = 7;
  localparam int unsigned OP_JMP    = 8;
  localparam int unsigned OP_JZ     = 9;
  localparam int unsigned OP_HALT   = 15;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RD_SRC = 3'd2,
    S_RD_DST = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // opcode | dest | src
  function automatic int instr_w(
    input int opc_w,
    input int addr_w
  );
    return opc_w + 2 * addr_w;
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: splits the instruction register into its fields.
// Ports: ir_i in; opcode/dest/src fields and class flags out.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter  int OPC_W   = 4,
  parameter  int ADDR_W  = 6,
  localparam int INSTR_W = instr_w(OPC_W, ADDR_W)
) (
  input  logic [INSTR_W-1:0] ir_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [ADDR_W-1:0]  dest_o,
  output logic [ADDR_W-1:0]  src_o,
  output logic               is_alu_o,
  output logic               is_mov_o,
  output logic               is_jump_o,
  output logic               is_halt_o,
  output logic               is_illegal_o
);

  logic is_nop;

  assign opcode_o = ir_i[INSTR_W-1 -: OPC_W];
  assign dest_o   = ir_i[2*ADDR_W-1:ADDR_W];
  assign src_o    = ir_i[ADDR_W-1:0];

  assign is_nop    = opcode_o == OPC_W'(OP_NOP);
  assign is_mov_o  = opcode_o == OPC_W'(OP_MOV);
  assign is_alu_o  = (opcode_o >= OPC_W'(OP_ALU_LO)) &&
                     (opcode_o <= OPC_W'(OP_ALU_HI));
  assign is_jump_o = (opcode_o == OPC_W'(OP_JMP)) ||
                     (opcode_o == OPC_W'(OP_JZ));
  assign is_halt_o = opcode_o == OPC_W'(OP_HALT);

  // Anything not recognised (10..14, and above 15 on wide opcodes)
  assign is_illegal_o = !(is_nop || is_mov_o || is_alu_o ||
                          is_jump_o || is_halt_o);

endmodule

// File: rtl/cpu_seq_core.sv
// cpu_seq_core: multi-cycle fetch/decode/execute sequencer with
// ready/ack ROM+RAM handshakes, external ALU, jumps, zero/halt/illegal.
// Ports: rom_* fetch, ram_* data access, alu_* external ALU, flags out.
module cpu_seq_core
  import cpu_pkg::*;
#(
  parameter  int OPC_W   = 4,
  parameter  int ADDR_W  = 6,
  parameter  int PC_W    = 8,
  parameter  int DATA_W  = 16,
  localparam int INSTR_W = instr_w(OPC_W, ADDR_W)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_rd,
  output logic               ram_wr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic               ram_ack,
  output logic [OPC_W-1:0]   alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_y,
  output logic               zero,
  output logic               halted,
  output logic               illegal
);

  state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  r_q, r_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic               halt_q, halt_d;

  logic               rom_req_q, rom_req_d;
  logic               ram_rd_q, ram_rd_d;
  logic               ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [OPC_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;

  logic [OPC_W-1:0]    op;
  logic [ADDR_W-1:0]   dest;
  logic [ADDR_W-1:0]   src;
  logic                is_alu;
  logic                is_mov;
  logic                is_jump;
  logic                is_halt;
  logic                is_illegal;
  logic                is_jz;
  logic                rom_ok;
  logic                ram_ok;
  logic [2*ADDR_W-1:0] tgt;

  cpu_decode #(
    .OPC_W  (OPC_W),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .ir_i         (ir_q),
    .opcode_o     (op),
    .dest_o       (dest),
    .src_o        (src),
    .is_alu_o     (is_alu),
    .is_mov_o     (is_mov),
    .is_jump_o    (is_jump),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  // An ack only counts while our own request is up
  assign rom_ok = rom_req_q & rom_ack;
  assign ram_ok = (ram_rd_q | ram_wr_q) & ram_ack;
  assign is_jz  = op == OPC_W'(OP_JZ);
  assign tgt    = {dest, src};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_FETCH: begin
        if (rom_ok) begin
          ir_d    = rom_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_halt:        state_d = S_HALT;
          is_alu, is_mov: state_d = S_RD_SRC;
          default:        state_d = S_FETCH;
        endcase
        if (is_illegal)
          ill_d = 1'b1;
        if (is_jump && (!is_jz || zero_q))
          pc_d = PC_W'(tgt);
      end
      S_RD_SRC: begin
        if (ram_ok) begin
          b_d     = ram_rdata;
          state_d = is_mov ? S_WRITE : S_RD_DST;
        end
      end
      S_RD_DST: begin
        if (ram_ok) begin
          a_d     = ram_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        r_d     = alu_y;
        zero_d  = alu_y == '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ram_ok)
          state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are registered from the state being entered, so a
  // request is up in the very first cycle of its state.
  always_comb begin
    rom_req_d  = state_d == S_FETCH;
    ram_rd_d   = (state_d == S_RD_SRC) ||
                 (state_d == S_RD_DST);
    ram_wr_d   = state_d == S_WRITE;
    halt_d     = state_d == S_HALT;
    ram_addr_d = '0;
    wdata_d    = '0;
    alu_op_d   = '0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    unique case (state_d)
      S_RD_SRC: ram_addr_d = src;
      S_RD_DST: ram_addr_d = dest;
      S_WRITE: begin
        ram_addr_d = dest;
        wdata_d    = is_mov ? b_d : r_d;
      end
      S_EXEC: begin
        alu_op_d = op;
        alu_a_d  = a_d;
        alu_b_d  = b_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      zero_q     <= 1'b0;
      ill_q      <= 1'b0;
      halt_q     <= 1'b0;
      rom_req_q  <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      zero_q     <= zero_d;
      ill_q      <= ill_d;
      halt_q     <= halt_d;
      rom_req_q  <= rom_req_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  assign rom_addr  = pc_q;
  assign rom_req   = rom_req_q;
  assign ram_addr  = ram_addr_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;
  assign ram_wdata = wdata_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign zero      = zero_q;
  assign halted    = halt_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_cpu_seq_core.sv
// tb_cpu_seq_core: ROM/RAM responders with wait states, bench ALU,
// instruction vector table and write scoreboard for cpu_seq_core.
module tb_cpu_seq_core;

  localparam int OPC_W   = 4;
  localparam int ADDR_W  = 6;
  localparam int PC_W    = 8;
  localparam int DATA_W  = 16;
  localparam int INSTR_W = OPC_W + 2 * ADDR_W;
  localparam int NV      = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [PC_W-1:0]    rom_addr;
  logic               rom_req;
  logic               rom_ack;
  logic [INSTR_W-1:0] rom_data;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_rd;
  logic               ram_wr;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;
  logic               ram_ack;
  logic [OPC_W-1:0]   alu_op;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_y;
  logic               zero;
  logic               halted;
  logic               illegal;

  cpu_seq_core #(
    .OPC_W  (OPC_W),
    .ADDR_W (ADDR_W),
    .PC_W   (PC_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_wr    (ram_wr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .zero      (zero),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Bench ALU: 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 b-a
  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'd2:    alu_y = alu_a + alu_b;
      4'd3:    alu_y = alu_a - alu_b;
      4'd4:    alu_y = alu_a & alu_b;
      4'd5:    alu_y = alu_a | alu_b;
      4'd6:    alu_y = alu_a ^ alu_b;
      4'd7:    alu_y = alu_b - alu_a;
      default: alu_y = '0;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  d;
    logic [5:0]  s;
    logic [15:0] dv;
    logic [15:0] sv;
    logic [15:0] w;
    logic        z;
    int          rw;
    int          lat;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] rom [256];
  logic [15:0] ram [64];
  wr_t         exp_q[$];
  vec_t        tv [NV];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int rom_wait = 0;
  int ram_wait = 0;
  int rom_cnt  = 0;
  int ram_cnt  = 0;
  bit late_ack = 1'b0;
  bit rise     = 1'b0;
  bit req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic chk_write();
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_write: addr %0h data %0h want none",
               ram_addr, ram_wdata);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr", 32'(ram_addr), 32'(e.addr));
      chk("wr_data", 32'(ram_wdata), 32'(e.data));
    end
    ram[ram_addr] = ram_wdata;
  endtask

  // One clock: sample at negedge, then answer ROM/RAM requests
  task automatic tick();
    @(negedge clk);
    cyc++;
    rise     = rom_req && !req_prev;
    req_prev = rom_req;
    if (reset) begin
      rom_ack = 1'b0;
      ram_ack = 1'b0;
      rom_cnt = 0;
      ram_cnt = 0;
      return;
    end
    if (rom_ack) rom_cnt = 0;
    rom_ack  = 1'b0;
    rom_data = 16'hF000;
    if (rom_req) begin
      if (rom_cnt >= rom_wait) begin
        rom_ack  = 1'b1;
        rom_data = rom[rom_addr];
      end else rom_cnt++;
    end else rom_cnt = 0;
    if (ram_ack) ram_cnt = 0;
    ram_ack   = 1'b0;
    ram_rdata = 16'hDEAD;
    if (late_ack) begin
      ram_ack  = 1'b1;
      late_ack = 1'b0;
    end else if (ram_rd || ram_wr) begin
      if (ram_cnt >= ram_wait) begin
        ram_ack = 1'b1;
        if (ram_rd) ram_rdata = ram[ram_addr];
        else chk_write();
      end else ram_cnt++;
    end else ram_cnt = 0;
  endtask

  task automatic wait_fetch(input logic [7:0] a, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 300) begin
      tick();
      n++;
      if (rise) begin
        chk("fetch_addr", 32'(rom_addr), 32'(a));
        t = cyc;
        return;
      end
    end
    checks++;
    $display("FAIL fetch_timeout: no fetch of %0h, want one", a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    late_ack = 1'b0;
    rom_wait = 0;
    ram_wait = 0;
  endtask

  task automatic quiet20(input string name);
    int busy;
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rom_req || ram_rd || ram_wr) busy++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tp, tn, n;
    bit found;
    reset     = 1'b0;
    rom_ack   = 1'b0;
    ram_ack   = 1'b0;
    rom_data  = '0;
    ram_rdata = '0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 64; i++) ram[i] = 16'h0000;

    tv[0] = '{4'd2, 6'd3,  6'd4,  16'd5,     16'd7,     16'd12,    1'b0, 0, 6};
    tv[1] = '{4'd3, 6'd5,  6'd6,  16'd9,     16'd9,     16'd0,     1'b1, 0, 6};
    tv[2] = '{4'd1, 6'd7,  6'd8,  16'h1111,  16'hABCD,  16'hABCD,  1'b1, 0, 4};
    tv[3] = '{4'd4, 6'd9,  6'd10, 16'hF0F0,  16'h0FF0,  16'h00F0,  1'b0, 2, 12};
    tv[4] = '{4'd5, 6'd11, 6'd12, 16'h1200,  16'h0034,  16'h1234,  1'b0, 0, 6};
    tv[5] = '{4'd6, 6'd13, 6'd13, 16'h5555,  16'h5555,  16'h0000,  1'b1, 0, 6};
    tv[6] = '{4'd0, 6'd0,  6'd0,  16'h0000,  16'h0000,  16'h0000,  1'b1, 0, 2};
    tv[7] = '{4'd2, 6'd14, 6'd15, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 0, 6};
    tv[8] = '{4'd7, 6'd16, 6'd17, 16'd3,     16'd10,    16'd7,     1'b0, 0, 6};
    tv[9] = '{4'd1, 6'd18, 6'd19, 16'h2222,  16'h0BAD,  16'h0BAD,  1'b0, 1, 6};

    // Asynchronous reset: outputs clear before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_rom_req",  32'(rom_req),   0);
    chk("rst_ram_rd",   32'(ram_rd),    0);
    chk("rst_ram_wr",   32'(ram_wr),    0);
    chk("rst_rom_addr", 32'(rom_addr),  0);
    chk("rst_ram_addr", 32'(ram_addr),  0);
    chk("rst_wdata",    32'(ram_wdata), 0);
    chk("rst_alu_op",   32'(alu_op),    0);
    chk("rst_alu_a",    32'(alu_a),     0);
    chk("rst_zero",     32'(zero),      0);
    chk("rst_halted",   32'(halted),    0);
    chk("rst_illegal",  32'(illegal),   0);
    tick();
    tick();
    reset = 1'b0;

    // Vector table program, terminated by HALT
    for (int i = 0; i < NV; i++) begin
      rom[i] = {tv[i].op, tv[i].d, tv[i].s};
      if (tv[i].op != 4'd0) begin
        ram[tv[i].d] = tv[i].dv;
        ram[tv[i].s] = tv[i].sv;
      end
    end
    rom[NV] = 16'hF000;
    ram_wait = tv[0].rw;
    wait_fetch(8'd0, tp);
    for (int i = 0; i < NV; i++) begin
      if (tv[i].op != 4'd0)
        exp_q.push_back('{tv[i].d, tv[i].w});
      wait_fetch(8'(i + 1), tn);
      chk($sformatf("lat_v%0d", i), 32'(tn - tp), 32'(tv[i].lat));
      chk($sformatf("zero_v%0d", i), 32'(zero), 32'(tv[i].z));
      tp = tn;
      if (i + 1 < NV) ram_wait = tv[i + 1].rw;
    end
    tick();
    tick();
    chk("halt_flag", 32'(halted), 1);
    quiet20("halt_quiet");
    chk("halt_no_illegal", 32'(illegal), 0);
    chk("sb_empty_a", 32'(exp_q.size()), 0);

    // ROM with three wait cycles: request held, IR loads on ack only
    do_reset();
    rom_wait = 3;
    rom[0] = 16'h0000;
    rom[1] = 16'h0000;
    wait_fetch(8'd0, tp);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("romw_req_held", 32'(rom_req), 1);
      chk("romw_addr_held", 32'(rom_addr), 0);
    end
    wait_fetch(8'd1, tn);
    chk("romw_nop_lat", 32'(tn - tp), 5);
    chk("romw_not_halted", 32'(halted), 0);

    // SUB to zero, JZ taken, SUB nonzero, JZ not taken, JMP, PC wrap
    do_reset();
    ram[20] = 16'd4;
    ram[21] = 16'd4;
    ram[22] = 16'd5;
    ram[23] = 16'd3;
    rom[8'h00] = {4'd3, 6'd20, 6'd21};
    rom[8'h01] = {4'd9, 6'd0, 6'h20};
    rom[8'h20] = {4'd3, 6'd22, 6'd23};
    rom[8'h21] = {4'd9, 6'd0, 6'h30};
    rom[8'h22] = {4'd8, 6'd3, 6'h3F};
    rom[8'hFF] = 16'h0000;
    wait_fetch(8'h00, tp);
    exp_q.push_back('{6'd20, 16'd0});
    wait_fetch(8'h01, tn);
    chk("jz_zero_set", 32'(zero), 1);
    wait_fetch(8'h20, tp);
    chk("jz_taken_lat", 32'(tp - tn), 2);
    exp_q.push_back('{6'd22, 16'd2});
    wait_fetch(8'h21, tn);
    chk("jz2_zero_clr", 32'(zero), 0);
    wait_fetch(8'h22, tp);
    chk("jz_not_taken_lat", 32'(tp - tn), 2);
    wait_fetch(8'hFF, tn);
    wait_fetch(8'h00, tp);
    chk("wrap_lat", 32'(tp - tn), 2);
    chk("sb_empty_d", 32'(exp_q.size()), 0);

    // Illegal opcode is sticky; then HALT
    do_reset();
    ram[24] = 16'd1;
    ram[25] = 16'd2;
    rom[0] = {4'd12, 6'd0, 6'd0};
    rom[1] = 16'h0000;
    rom[2] = {4'd2, 6'd24, 6'd25};
    rom[3] = 16'hF000;
    wait_fetch(8'd0, tp);
    chk("ill_before", 32'(illegal), 0);
    wait_fetch(8'd1, tn);
    chk("ill_set", 32'(illegal), 1);
    chk("ill_lat", 32'(tn - tp), 2);
    exp_q.push_back('{6'd24, 16'd3});
    wait_fetch(8'd2, tn);
    wait_fetch(8'd3, tn);
    chk("ill_sticky", 32'(illegal), 1);
    tick();
    tick();
    chk("ill_halted", 32'(halted), 1);
    quiet20("ill_halt_quiet");
    chk("ill_sticky_end", 32'(illegal), 1);
    chk("sb_empty_e", 32'(exp_q.size()), 0);

    // Reset while RD_DST waits for its ack
    do_reset();
    ram[26] = 16'h0100;
    ram[27] = 16'h0023;
    rom[0] = {4'd2, 6'd26, 6'd27};
    rom[1] = 16'hF000;
    ram_wait = 5;
    wait_fetch(8'd0, tp);
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      if (ram_rd && ram_addr == 6'd26) found = 1'b1;
    end
    chk("rdst_reached", 32'(found), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ram_rd", 32'(ram_rd), 0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 0);
    chk("mid_rst_pc", 32'(rom_addr), 0);
    chk("mid_rst_rom_req", 32'(rom_req), 0);
    tick();
    tick();
    reset    = 1'b0;
    ram_wait = 0;
    late_ack = 1'b1;
    wait_fetch(8'd0, tp);
    exp_q.push_back('{6'd26, 16'h0123});
    wait_fetch(8'd1, tn);
    chk("post_rst_lat", 32'(tn - tp), 6);
    chk("sb_empty_f", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
